// File: rtl/shift_register_8bit.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_8bit
// Description : Serial-in, parallel-out / serial-out shift register with a
//               shift enable. Serves as a serial-to-parallel converter or a
//               WIDTH-stage delay line between serial links and parallel
//               datapaths.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        register length in bits (>= 2)
//   RESET_VALUE  contents loaded while rst_n is low
//   SHIFT_LEFT   1: data enters bit 0 and moves up, serial_out = bit WIDTH-1
//                0: data enters bit WIDTH-1 and moves down, serial_out = bit 0
// Ports
//   clk           in   1      system clock, rising-edge active
//   rst_n         in   1      asynchronous active-low reset
//   shift_en      in   1      shift enable, sampled on rising clk
//   serial_in     in   1      bit shifted in on an enabled edge
//   parallel_out  out  WIDTH  current register contents
//   serial_out    out  1      bit that leaves on the next enabled shift
// ============================================================================
module shift_register_8bit #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter bit                 SHIFT_LEFT  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  parallel_out,
  output logic              serial_out
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_serial_out;

  // Direction is fixed at elaboration, so only one data path is built.
  generate
    if (SHIFT_LEFT) begin : g_shift_left
      // New bit lands in bit 0; the old MSB is the one that falls off.
      assign w_shift_next = {r_shift[WIDTH-2:0], serial_in};
      assign w_serial_out = r_shift[WIDTH-1];
    end else begin : g_shift_right
      // New bit lands in the MSB; the old LSB is the one that falls off.
      assign w_shift_next = {serial_in, r_shift[WIDTH-1:1]};
      assign w_serial_out = r_shift[0];
    end
  endgenerate

  // Reset is asynchronous and dominates the enable, so an edge that
  // coincides with rst_n low never performs a partial shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= RESET_VALUE;
    end else if (shift_en) begin
      r_shift <= w_shift_next;
    end
  end

  // Both outputs come straight off the register: serial_out is the exit
  // bit with no extra pipeline stage.
  assign parallel_out = r_shift;
  assign serial_out   = w_serial_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_8bit
// Description : Directed, self-checking bench for shift_register_8bit.
//               Instantiates the default 8-bit left shifter and a 4-bit
//               right shifter; expected values are queued when stimulus is
//               driven and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_8bit;

  logic       clk;
  logic       rst_n;
  logic       shift_en;
  logic       serial_in;
  logic [7:0] parallel_out;
  logic       serial_out;

  logic       shift_en4;
  logic       serial_in4;
  logic [3:0] parallel_out4;
  logic       serial_out4;

  int checks   = 0;
  int failures = 0;

  logic [7:0] r_model8;
  logic [3:0] r_model4;
  logic [7:0] q_exp8[$];
  logic [3:0] q_exp4[$];

  shift_register_8bit u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en     (shift_en),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .serial_out   (serial_out)
  );

  shift_register_8bit #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000),
    .SHIFT_LEFT  (1'b0)
  ) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en     (shift_en4),
    .serial_in    (serial_in4),
    .parallel_out (parallel_out4),
    .serial_out   (serial_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one edge on the 8-bit DUT, queue the model result, compare after.
  task automatic step8(input string tag, input logic en, input logic din);
    logic [7:0] exp;
    @(negedge clk);
    shift_en  = en;
    serial_in = din;
    if (en) r_model8 = {r_model8[6:0], din};
    q_exp8.push_back(r_model8);
    @(posedge clk);
    #1;
    exp = q_exp8.pop_front();
    check8(tag, parallel_out, exp);
    check1({tag, "_sout"}, serial_out, exp[7]);
  endtask

  task automatic step4(input string tag, input logic din);
    logic [3:0] exp;
    @(negedge clk);
    shift_en4  = 1'b1;
    serial_in4 = din;
    r_model4   = {din, r_model4[3:1]};
    q_exp4.push_back(r_model4);
    @(posedge clk);
    #1;
    exp = q_exp4.pop_front();
    check4(tag, parallel_out4, exp);
    check1({tag, "_sout"}, serial_out4, exp[0]);
  endtask

  initial begin
    rst_n      = 1'b1;
    shift_en   = 1'b0;
    serial_in  = 1'b0;
    shift_en4  = 1'b0;
    serial_in4 = 1'b0;
    r_model8   = 8'h00;
    r_model4   = 4'h0;

    // Asynchronous reset between edges (first rising edge is at t=5).
    #2 rst_n = 1'b0;
    #1;
    check8("async_reset_pout", parallel_out, 8'h00);
    check1("async_reset_sout", serial_out, 1'b0);
    check4("async_reset_pout4", parallel_out4, 4'h0);

    // Hold reset across an enabled edge: reset must win.
    shift_en  = 1'b1;
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    check8("reset_beats_shift", parallel_out, 8'h00);
    @(negedge clk);
    shift_en = 1'b0;
    rst_n    = 1'b1;
    #1;
    check8("release_no_clock", parallel_out, 8'h00);

    // Hold: enable low, serial_in high for two edges.
    step8("hold0", 1'b0, 1'b1);
    step8("hold1", 1'b0, 1'b1);

    // Alternating pattern 0,1,0,1,...
    for (int i = 0; i < 8; i++) begin
      step8($sformatf("alt%0d", i), 1'b1, logic'(i % 2));
    end
    check8("alt_final", parallel_out, 8'b0101_0101);
    check1("alt_final_sout", serial_out, 1'b0);

    // Hold in the middle of data.
    step8("hold_mid", 1'b0, 1'b1);

    // Eight ones.
    for (int i = 0; i < 8; i++) begin
      step8($sformatf("ones%0d", i), 1'b1, 1'b1);
    end
    check8("ones_final", parallel_out, 8'hFF);
    check1("ones_final_sout", serial_out, 1'b1);

    // Reset mid-operation, 5 time units after an edge, no clock needed.
    @(negedge clk);
    shift_en  = 1'b1;
    serial_in = 1'b0;
    @(posedge clk);
    r_model8 = {r_model8[6:0], 1'b0};
    #1;
    check8("pre_midreset", parallel_out, r_model8);
    #4 rst_n = 1'b0;
    r_model8 = 8'h00;
    #1;
    check8("mid_reset_pout", parallel_out, 8'h00);
    check1("mid_reset_sout", serial_out, 1'b0);
    @(negedge clk);
    shift_en = 1'b0;
    #2 rst_n = 1'b1;

    // Bit latency: a single 1 reaches serial_out after eight shifts.
    step8("lat0", 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step8($sformatf("lat%0d", i), 1'b1, 1'b0);
    end
    check1("latency_sout", serial_out, 1'b1);

    // 4-bit right shifter: 1,0,0,0 -> 0001, serial_out = 1.
    step4("r4_0", 1'b1);
    step4("r4_1", 1'b0);
    step4("r4_2", 1'b0);
    step4("r4_3", 1'b0);
    check4("r4_final", parallel_out4, 4'b0001);
    check1("r4_final_sout", serial_out4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
